// File: rtl/ctu_clkgn_pkg.sv
// Shared definitions for the CTU clock-generation cluster: sequencer state
// encodings and parameter defaults for the per-domain cken sequencer.
package ctu_clkgn_pkg;

    localparam logic [2:0] ST_STOP       = 3'd0;
    localparam logic [2:0] ST_WAIT_START = 3'd1;
    localparam logic [2:0] ST_RUN        = 3'd2;
    localparam logic [2:0] ST_WAIT_STOP  = 3'd3;
    localparam logic [2:0] ST_DRAIN      = 3'd4;
    localparam logic [2:0] ST_NSTEP      = 3'd5;

    localparam int STOP_DLY_DEF = 2;
    localparam int CNT_W_DEF    = 4;

endpackage

// File: rtl/ctu_clsp_clkgn_cken_seq_if.sv
// Request/status bundle of the cken sequencer. seq_err exists only when
// CTU_CKEN_SEQ_ERRCHK_EN is defined.
interface ctu_clsp_clkgn_cken_seq_if
    import ctu_clkgn_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             coin_edge;
    logic             start_req;
    logic             stop_req;
    logic             nstep_sel;
    logic             force_cken;
    logic             testmode_l;
    logic             cken;
    logic             step_done;
    logic [CNT_W-1:0] step_cnt;
    logic [2:0]       seq_state;
`ifdef CTU_CKEN_SEQ_ERRCHK_EN
    logic             seq_err;
`endif

    modport master (
        output coin_edge, start_req, stop_req, nstep_sel, force_cken, testmode_l,
        input  cken, step_done, step_cnt, seq_state
`ifdef CTU_CKEN_SEQ_ERRCHK_EN
        , input seq_err
`endif
    );

    modport slave (
        input  coin_edge, start_req, stop_req, nstep_sel, force_cken, testmode_l,
        output cken, step_done, step_cnt, seq_state
`ifdef CTU_CKEN_SEQ_ERRCHK_EN
        , output seq_err
`endif
    );

endinterface

// File: rtl/ctu_clsp_clkgn_satcnt.sv
// Saturating up-counter with synchronous clear; clear and enable together
// load 1 so the first counted cycle of a burst is not lost.
module ctu_clsp_clkgn_satcnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= {{(W-1){1'b0}}, en};
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/ctu_clsp_clkgn_cken_seq.sv
// Per-domain clock-enable sequencer: merges start/stop, coin_edge and nstep
// into a registered cken. Optional sticky seq_err under CTU_CKEN_SEQ_ERRCHK_EN.
module ctu_clsp_clkgn_cken_seq
    import ctu_clkgn_pkg::*;
#(
    parameter int STOP_DLY = STOP_DLY_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      io_pwron_rst,
    ctu_clsp_clkgn_cken_seq_if.slave  bus
);

    localparam logic [2:0] DLY_LOAD = 3'(STOP_DLY);

    logic [2:0] state_reg, state_next;
    logic [2:0] dly_reg, dly_next;
    logic       cken_reg, fsm_cken_next;
    logic       done_reg, done_next;
    logic       cnt_clr, cnt_en;
    logic       override;

    assign override = bus.force_cken | ~bus.testmode_l;

    // cken_next reflects the state being entered, so a burst or a RUN starts
    // with cken high on the cycle right after the triggering input.
    always_comb begin
        state_next    = state_reg;
        dly_next      = dly_reg;
        fsm_cken_next = 1'b0;
        done_next     = 1'b0;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;
        case (state_reg)
            ST_STOP: begin
                if (!bus.stop_req) begin
                    if (bus.nstep_sel) begin
                        state_next    = ST_NSTEP;
                        fsm_cken_next = 1'b1;
                        cnt_clr       = 1'b1;
                        cnt_en        = 1'b1;
                    end else if (bus.start_req) begin
                        state_next = ST_WAIT_START;
                    end
                end
            end
            ST_WAIT_START: begin
                if (bus.stop_req) begin
                    state_next = ST_STOP;
                end else if (bus.coin_edge) begin
                    state_next    = ST_RUN;
                    fsm_cken_next = 1'b1;
                end
            end
            ST_RUN: begin
                fsm_cken_next = 1'b1;
                if (bus.stop_req) begin
                    state_next = ST_WAIT_STOP;
                end
            end
            ST_WAIT_STOP: begin
                fsm_cken_next = 1'b1;
                if (bus.coin_edge) begin
                    if (STOP_DLY == 0) begin
                        state_next    = ST_STOP;
                        fsm_cken_next = 1'b0;
                    end else begin
                        state_next = ST_DRAIN;
                        dly_next   = DLY_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                if (dly_reg > 3'd1) begin
                    fsm_cken_next = 1'b1;
                    dly_next      = dly_reg - 3'd1;
                end else begin
                    state_next = ST_STOP;
                    dly_next   = 3'd0;
                end
            end
            ST_NSTEP: begin
                if (bus.nstep_sel) begin
                    fsm_cken_next = 1'b1;
                    cnt_en        = 1'b1;
                end else begin
                    state_next = ST_STOP;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_STOP;
                dly_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge io_pwron_rst) begin
        if (io_pwron_rst) begin
            state_reg <= ST_STOP;
            dly_reg   <= 3'd0;
            cken_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            dly_reg   <= dly_next;
            cken_reg  <= fsm_cken_next | override;
            done_reg  <= done_next;
        end
    end

    ctu_clsp_clkgn_satcnt #(.W(CNT_W)) u_step_cnt (
        .clk (clk),
        .rst (io_pwron_rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (bus.step_cnt)
    );

    assign bus.cken      = cken_reg;
    assign bus.step_done = done_reg;
    assign bus.seq_state = state_reg;

`ifdef CTU_CKEN_SEQ_ERRCHK_EN
    logic err_reg;
    logic err_set;

    // nstep has no meaning outside STOP/NSTEP; conflicting start/stop is a driver bug.
    assign err_set = (bus.nstep_sel && ((state_reg == ST_RUN) ||
                                        (state_reg == ST_WAIT_START) ||
                                        (state_reg == ST_WAIT_STOP))) ||
                     (bus.start_req && bus.stop_req);

    always_ff @(posedge clk or posedge io_pwron_rst) begin
        if (io_pwron_rst) begin
            err_reg <= 1'b0;
        end else if (err_set) begin
            err_reg <= 1'b1;
        end
    end

    assign bus.seq_err = err_reg;
`endif

endmodule
